// File: rtl/enable_handover_if.sv
// ============================================================================
//  enable_handover_if : request/sample inputs and enable/data outputs of the
//  enable_handover stage.            Revision: 1.0
// ============================================================================
`default_nettype none

interface enable_handover_if #(
  parameter int DATA_W = 8
);
  logic              switch_req;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              enable_1;
  logic              enable_2;
  logic              busy;
  logic              switch_ack;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_sel;
  logic [7:0]        clamp_cnt;

  modport master (
    output switch_req, din, din_valid,
    input  enable_1, enable_2, busy, switch_ack,
    input  dout, dout_valid, dout_sel, clamp_cnt
  );

  modport slave (
    input  switch_req, din, din_valid,
    output enable_1, enable_2, busy, switch_ack,
    output dout, dout_valid, dout_sel, clamp_cnt
  );
endinterface

`default_nettype wire

// File: rtl/enable_handover.sv
// ============================================================================
//  enable_handover : make-before-break channel enable handover plus a
//  registered, clamped sample path.   Revision: 1.0
// ============================================================================
`default_nettype none

module enable_handover #(
  parameter int DATA_W   = 8,
  parameter int MAX_DATA = 200,
  parameter int OVERLAP  = 2
) (
  input  wire                 clk,
  input  wire                 reset,
  enable_handover_if.slave    bus
);

  localparam logic [1:0] CH1      = 2'd0;
  localparam logic [1:0] OVL_TO_2 = 2'd1;
  localparam logic [1:0] CH2      = 2'd2;
  localparam logic [1:0] OVL_TO_1 = 2'd3;

  localparam logic [3:0]        OVL_LOAD = 4'(OVERLAP - 1);
  localparam logic [DATA_W-1:0] MAX_VAL  = DATA_W'(MAX_DATA);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       ack_nxt;
  logic       over_max;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack_nxt   = 1'b0;
    case (state)
      CH1: begin
        if (bus.switch_req) begin
          state_nxt = OVL_TO_2;
          cnt_nxt   = OVL_LOAD;
        end
      end
      OVL_TO_2: begin
        if (cnt == 4'd0) begin
          state_nxt = CH2;
          ack_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      CH2: begin
        if (bus.switch_req) begin
          state_nxt = OVL_TO_1;
          cnt_nxt   = OVL_LOAD;
        end
      end
      OVL_TO_1: begin
        if (cnt == 4'd0) begin
          state_nxt = CH1;
          ack_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = CH1;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign over_max = (bus.din > MAX_VAL);

  // Enables are decoded from the next state so they change on the same edge
  // as the state register; the rising enable never lags the falling one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= CH1;
      cnt            <= 4'd0;
      bus.enable_1   <= 1'b1;
      bus.enable_2   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.switch_ack <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      bus.enable_1   <= (state_nxt != CH2);
      bus.enable_2   <= (state_nxt != CH1);
      bus.busy       <= (state_nxt == OVL_TO_2) || (state_nxt == OVL_TO_1);
      bus.switch_ack <= ack_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.dout_sel   <= 1'b0;
      bus.clamp_cnt  <= 8'd0;
    end else begin
      bus.dout_valid <= bus.din_valid;
      bus.dout_sel   <= (state == CH2) || (state == OVL_TO_2);
      if (bus.din_valid) begin
        bus.dout <= over_max ? MAX_VAL : bus.din;
        if (over_max && (bus.clamp_cnt != 8'hFF)) begin
          bus.clamp_cnt <= bus.clamp_cnt + 8'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_enable_handover.sv
// ============================================================================
//  tb_enable_handover : random and directed stimulus against a channel-level
//  reference model.                   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_enable_handover;

  localparam int DATA_W   = 8;
  localparam int MAX_DATA = 200;
  localparam int OVERLAP  = 2;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  enable_handover_if #(.DATA_W(DATA_W)) bus ();

  enable_handover #(
    .DATA_W   (DATA_W),
    .MAX_DATA (MAX_DATA),
    .OVERLAP  (OVERLAP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: which channel owns (or is becoming owner of) the stream, and
  // how many overlap cycles remain before the handover completes.
  int   m_tgt;
  int   m_left;
  logic m_ack;
  int   m_dout;
  logic m_dv;
  logic m_sel;
  int   m_clamp;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic q, input int d, input logic v);
    if (r) begin
      m_tgt = 1; m_left = 0; m_ack = 1'b0;
      m_dout = 0; m_dv = 1'b0; m_sel = 1'b0; m_clamp = 0;
    end else begin
      m_sel = (m_tgt == 2);
      m_dv  = v;
      if (v) begin
        m_dout = (d > MAX_DATA) ? MAX_DATA : d;
        if (d > MAX_DATA) m_clamp = (m_clamp < 255) ? m_clamp + 1 : 255;
      end
      m_ack = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_ack = 1'b1;
      end else if (q) begin
        m_tgt  = 3 - m_tgt;
        m_left = OVERLAP;
      end
    end
  endtask

  task automatic step(input logic r, input logic q, input int d, input logic v);
    reset          = r;
    bus.switch_req = q;
    bus.din        = DATA_W'(d);
    bus.din_valid  = v;
    @(posedge clk);
    model(r, q, d, v);
    #1;
    check_eq("enable_1",   32'(bus.enable_1),   32'((m_left > 0) || (m_tgt == 1)));
    check_eq("enable_2",   32'(bus.enable_2),   32'((m_left > 0) || (m_tgt == 2)));
    check_eq("any_enable", 32'(bus.enable_1 | bus.enable_2), 32'd1);
    check_eq("busy",       32'(bus.busy),       32'(m_left > 0));
    check_eq("switch_ack", 32'(bus.switch_ack), 32'(m_ack));
    check_eq("dout",       32'(bus.dout),       32'(m_dout));
    check_eq("dout_valid", 32'(bus.dout_valid), 32'(m_dv));
    check_eq("dout_sel",   32'(bus.dout_sel),   32'(m_sel));
    check_eq("clamp_cnt",  32'(bus.clamp_cnt),  32'(m_clamp));
  endtask

  int samples [6] = '{0, 199, 200, 201, 210, 255};

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.switch_req = 1'b0;
    bus.din        = '0;
    bus.din_valid  = 1'b0;

    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 255, 1'b1);

    // idle after reset: channel 1 stays active
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 0, 1'b0);

    // single request pulse, then let it settle
    step(1'b0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0, 1'b0);

    // continuous request: ping-pong with dropped overlap requests
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 1'b0);

    // clamp boundary samples
    step(1'b1, 1'b0, 0, 1'b0);
    foreach (samples[i]) step(1'b0, 1'b0, samples[i], 1'b1);
    step(1'b0, 1'b0, 17, 1'b0);
    check_eq("clamp_after_table", 32'(bus.clamp_cnt), 32'd3);

    // saturation of the clamp counter
    for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 255, 1'b1);
    check_eq("clamp_saturated", 32'(bus.clamp_cnt), 32'd255);

    // reset in the second overlap cycle, then a fresh handover
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
    check_eq("reset_mid_ovl_en2", 32'(bus.enable_2), 32'd0);
    step(1'b0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 1) ? int'($urandom_range(180, 255)) : int'($urandom_range(0, 255)),
           ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
